// File: rtl/ahb_cfg_ctrl.sv
// ahb_cfg_ctrl: AHB-Lite slave front end for a bank of NREG 32-bit config registers.
//
// Decodes the register index from the byte address, issues one-hot write/read
// enables to the register bank, and returns the bank's OR-combined read data.
// Illegal accesses get a two-cycle ERROR response and never raise an enable.
//
// Build option:
//   AHB_CFG_CTRL_RDWAIT_EN  defined   : reads take one wait state (RD1) and
//                                       hrdata_o is registered (valid in RD2).
//                           undefined : reads complete with zero wait states;
//                                       hrdata_o is a combinational pass-through
//                                       of reg_rdata_i in RD, zero elsewhere.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   hsel_i .. hready_i  AHB-Lite slave address/data phase inputs
//   hrdata_o            read data
//   hreadyout_o         slave ready
//   hresp_o             0 = OKAY, 1 = ERROR
//   reg_wen_o           one-hot write enable pulse to the register bank
//   reg_ren_o           one-hot read enable to the register bank
//   reg_wdata_o         write data to the register bank
//   reg_rdata_i         OR of all register read outputs
module ahb_cfg_ctrl #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hsel_i,
  input  logic [AW+1:0]   haddr_i,
  input  logic [1:0]      htrans_i,
  input  logic            hwrite_i,
  input  logic [2:0]      hsize_i,
  input  logic [31:0]     hwdata_i,
  input  logic            hready_i,
  output logic [31:0]     hrdata_o,
  output logic            hreadyout_o,
  output logic            hresp_o,
  output logic [NREG-1:0] reg_wen_o,
  output logic [NREG-1:0] reg_ren_o,
  output logic [31:0]     reg_wdata_o,
  input  logic [31:0]     reg_rdata_i
);

`ifdef AHB_CFG_CTRL_RDWAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD1, S_RD2, S_ER1, S_ER2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ER1, S_ER2} state_t;
`endif

  state_t        state, nxt;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] addr_idx;
  logic          accept;
  logic          legal;
  logic          can_acc;
  logic          rd_state;

  assign addr_idx = haddr_i[AW+1:2];
  assign accept   = hsel_i & htrans_i[1] & hready_i;
  // Widen the index by one bit so NREG == 2^AW compares without overflow.
  assign legal    = ({1'b0, addr_idx} < (AW+1)'(NREG)) &&
                    (haddr_i[1:0] == 2'b00) && (hsize_i == 3'b010);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx_q <= '0;
    end else begin
      state <= nxt;
      if (can_acc && accept && legal) idx_q <= addr_idx;
    end
  end

  // Next state: any state whose data phase completes this cycle (hreadyout_o=1)
  // can take the next address phase.
  always_comb begin
    nxt     = state;
    can_acc = 1'b0;
    unique case (state)
      S_IDLE, S_WR, S_ER2: can_acc = 1'b1;
`ifdef AHB_CFG_CTRL_RDWAIT_EN
      S_RD1:               nxt     = S_RD2;
      S_RD2:               can_acc = 1'b1;
`else
      S_RD:                can_acc = 1'b1;
`endif
      S_ER1:               nxt     = S_ER2;
      default:             nxt     = S_IDLE;
    endcase
    if (can_acc) begin
      if (accept) begin
        if (!legal)        nxt = S_ER1;
        else if (hwrite_i) nxt = S_WR;
`ifdef AHB_CFG_CTRL_RDWAIT_EN
        else               nxt = S_RD1;
`else
        else               nxt = S_RD;
`endif
      end else begin
        nxt = S_IDLE;
      end
    end
  end

`ifdef AHB_CFG_CTRL_RDWAIT_EN
  assign rd_state    = (state == S_RD1);
  assign hreadyout_o = !((state == S_RD1) || (state == S_ER1));

  // Read data is captured at the end of RD1 and held through later writes/errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             hrdata_o <= '0;
    else if (state == S_RD1) hrdata_o <= reg_rdata_i;
  end
`else
  assign rd_state    = (state == S_RD);
  assign hreadyout_o = (state != S_ER1);
  assign hrdata_o    = rd_state ? reg_rdata_i : 32'h0;
`endif

  assign hresp_o     = (state == S_ER1) || (state == S_ER2);
  assign reg_wdata_o = (state == S_WR) ? hwdata_i : 32'h0;

  // idx_q only ever holds a legal index, so at most one enable bit is set.
  always_comb begin
    reg_wen_o = '0;
    reg_ren_o = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_wen_o[i] = (state == S_WR) && (idx_q == AW'(i));
      reg_ren_o[i] = rd_state        && (idx_q == AW'(i));
    end
  end

endmodule

// File: tb/tb_ahb_cfg_ctrl.sv
// Directed bench for ahb_cfg_ctrl (NREG=8, AW=4 so index 8 is addressable).
// Each stimulus cycle pushes the hand-computed expected outputs; a monitor pops
// and compares them at the falling edge. A small register-bank model closes the
// loop on reg_wen_o/reg_ren_o/reg_rdata_i.
module tb_ahb_cfg_ctrl;
  localparam int NREG = 8;
  localparam int AW   = 4;

`ifdef AHB_CFG_CTRL_RDWAIT_EN
  localparam logic [31:0] HA5 = 32'hA5A5_1234;  // held after first read
  localparam logic [31:0] H11 = 32'h1111_2222;  // held after second read
`else
  localparam logic [31:0] HA5 = 32'h0;
  localparam logic [31:0] H11 = 32'h0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hsel_i = 1'b0;
  logic [AW+1:0]   haddr_i = '0;
  logic [1:0]      htrans_i = 2'b00;
  logic            hwrite_i = 1'b0;
  logic [2:0]      hsize_i = 3'b010;
  logic [31:0]     hwdata_i = '0;
  logic            hready_i = 1'b1;
  logic [31:0]     hrdata_o;
  logic            hreadyout_o;
  logic            hresp_o;
  logic [NREG-1:0] reg_wen_o;
  logic [NREG-1:0] reg_ren_o;
  logic [31:0]     reg_wdata_o;
  logic [31:0]     reg_rdata_i;

  ahb_cfg_ctrl #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel_i), .haddr_i(haddr_i),
    .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i),
    .hwdata_i(hwdata_i), .hready_i(hready_i), .hrdata_o(hrdata_o),
    .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .reg_wen_o(reg_wen_o),
    .reg_ren_o(reg_ren_o), .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk = ~clk;

  // Register bank model
  logic [31:0] regs [NREG] = '{default: 32'h0};
  always @(posedge clk)
    for (int i = 0; i < NREG; i++)
      if (reg_wen_o[i]) regs[i] <= reg_wdata_o;
  always_comb begin
    reg_rdata_i = 32'h0;
    for (int i = 0; i < NREG; i++)
      if (reg_ren_o[i]) reg_rdata_i = reg_rdata_i | regs[i];
  end

  typedef struct packed {
    logic        hr;
    logic        rs;
    logic [31:0] rd;
    logic [7:0]  we;
    logic [7:0]  re;
    logic [31:0] wd;
  } resp_t;

  resp_t exp_q [$];
  string name_q [$];
  int n_chk = 0;
  int n_pass = 0;
  logic hrdy = 1'b1;

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      resp_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{hreadyout_o, hresp_o, hrdata_o, reg_wen_o, reg_ren_o, reg_wdata_o};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got rdy=%0b resp=%0b rdata=%h wen=%b ren=%b wdata=%h, want rdy=%0b resp=%0b rdata=%h wen=%b ren=%b wdata=%h",
                    nm, a.hr, a.rs, a.rd, a.we, a.re, a.wd, e.hr, e.rs, e.rd, e.we, e.re, e.wd);
    end
  end

  task automatic step(input string nm, input logic sel, input logic [1:0] tr,
                      input logic wr, input logic [AW+1:0] ad, input logic [2:0] sz,
                      input logic [31:0] wdi, input logic hr, input logic rs,
                      input logic [31:0] rd, input logic [7:0] we,
                      input logic [7:0] re, input logic [31:0] wdo);
    @(posedge clk);
    #1;
    hsel_i = sel; htrans_i = tr; hwrite_i = wr; haddr_i = ad; hsize_i = sz;
    hwdata_i = wdi; hready_i = hrdy;
    exp_q.push_back('{hr, rs, rd, we, re, wdo});
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [31:0] wdi, input logic hr,
                      input logic rs, input logic [31:0] rd, input logic [7:0] we,
                      input logic [7:0] re, input logic [31:0] wdo);
    step(nm, 1'b0, 2'b00, 1'b0, '0, 3'b010, wdi, hr, rs, rd, we, re, wdo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle("reset", 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // single write then read of index 2
    step("wr_a", 1, 2'b10, 1, 6'h08, 3'b010, 0, 1, 0, 0, 0, 0, 0);
    idle("wr_d", 32'hA5A5_1234, 1, 0, 0, 8'h04, 0, 32'hA5A5_1234);
    idle("wr_done", 0, 1, 0, 0, 0, 0, 0);
    step("rd_a", 1, 2'b10, 0, 6'h08, 3'b010, 0, 1, 0, 0, 0, 0, 0);
`ifdef AHB_CFG_CTRL_RDWAIT_EN
    idle("rd1", 0, 0, 0, 0, 0, 8'h04, 0);
    idle("rd2", 0, 1, 0, 32'hA5A5_1234, 0, 0, 0);
`else
    idle("rd", 0, 1, 0, 32'hA5A5_1234, 0, 8'h04, 0);
`endif
    idle("rd_hold", 0, 1, 0, HA5, 0, 0, 0);

    // back-to-back write then read of index 1
    step("b2b_wa", 1, 2'b10, 1, 6'h04, 3'b010, 0, 1, 0, HA5, 0, 0, 0);
    step("b2b_wd_ra", 1, 2'b10, 0, 6'h04, 3'b010, 32'h1111_2222, 1, 0, HA5, 8'h02, 0, 32'h1111_2222);
`ifdef AHB_CFG_CTRL_RDWAIT_EN
    idle("b2b_rd1", 0, 0, 0, 32'hA5A5_1234, 0, 8'h02, 0);
    idle("b2b_rd2", 0, 1, 0, 32'h1111_2222, 0, 0, 0);
`else
    idle("b2b_rd", 0, 1, 0, 32'h1111_2222, 0, 8'h02, 0);
`endif
    idle("b2b_done", 0, 1, 0, H11, 0, 0, 0);

    // errors: out-of-range index, bad size, then legal write from ER2
    step("err_idx_a", 1, 2'b10, 0, 6'h20, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    idle("err_idx_er1", 0, 0, 1, H11, 0, 0, 0);
    step("err_idx_er2", 1, 2'b10, 1, 6'h00, 3'b001, 0, 1, 1, H11, 0, 0, 0);
    idle("err_sz_er1", 32'hDEAD_BEEF, 0, 1, H11, 0, 0, 0);
    step("err_sz_er2", 1, 2'b10, 1, 6'h0C, 3'b010, 32'hDEAD_BEEF, 1, 1, H11, 0, 0, 0);
    idle("wr_c", 32'hCAFE_F00D, 1, 0, H11, 8'h08, 0, 32'hCAFE_F00D);

    // non-transfers and misalignment
    step("htrans_idle", 1, 2'b00, 1, 6'h08, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    step("htrans_busy", 1, 2'b01, 1, 6'h08, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    step("hsel_lo", 0, 2'b10, 1, 6'h08, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    step("misalign_a", 1, 2'b10, 0, 6'h09, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    idle("misalign_er1", 0, 0, 1, H11, 0, 0, 0);
    idle("misalign_er2", 0, 1, 1, H11, 0, 0, 0);
    hrdy = 1'b0;
    step("hready_lo", 1, 2'b10, 1, 6'h08, 3'b010, 0, 1, 0, H11, 0, 0, 0);
    hrdy = 1'b1;
    idle("hready_lo_chk", 32'h5555_5555, 1, 0, H11, 0, 0, 0);

    // reset during a read data phase
    step("rd_c_a", 1, 2'b10, 0, 6'h0C, 3'b010, 0, 1, 0, H11, 0, 0, 0);
`ifdef AHB_CFG_CTRL_RDWAIT_EN
    idle("rd_c_rd1", 0, 0, 0, 32'h1111_2222, 0, 8'h08, 0);
`else
    idle("rd_c", 0, 1, 0, 32'hCAFE_F00D, 0, 8'h08, 0);
`endif
    @(negedge clk); #2 rst_n = 1'b0;
    idle("rst_mid", 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    idle("rst_done", 0, 1, 0, 0, 0, 0, 0);

    // normal read after reset still returns bank contents
    step("rd_b_a", 1, 2'b10, 0, 6'h04, 3'b010, 0, 1, 0, 0, 0, 0, 0);
`ifdef AHB_CFG_CTRL_RDWAIT_EN
    idle("rd_b_rd1", 0, 0, 0, 0, 0, 8'h02, 0);
    idle("rd_b_rd2", 0, 1, 0, 32'h1111_2222, 0, 0, 0);
`else
    idle("rd_b", 0, 1, 0, 32'h1111_2222, 0, 8'h02, 0);
`endif
    idle("end", 0, 1, 0, H11, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
